// File: rtl/uart_tx_arbiter_pkg.sv
// Shared helpers for the UART transmit arbiter: index wrap for round-robin pointers.
package uart_tx_arbiter_pkg;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin winner selection: first asserted request at or after ptr, wrapping to 0.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    index
);

  always_comb begin
    int k;
    valid = 1'b0;
    index = '0;
    k     = int'(ptr);
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && req[k]) begin
        valid = 1'b1;
        index = IW'(k);
      end
      k = wrap_inc(k, N_REQ);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte streams onto one UART transmitter, keeping packets contiguous
// and releasing a stalled packet owner after HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_active,
  output logic                     hold_timeout,
  output logic [1:0]               state_dbg
);

  localparam int GW  = $clog2(N_REQ);
  localparam int HCW = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_q;
  logic            last_q;
  logic [7:0]      tx_data_q;
  logic [HCW-1:0]  hold_cnt_q;
  logic            hold_to_q;

  logic            sel_valid;
  logic [GW-1:0]   sel_idx;
  logic            xfer;
  logic [GW-1:0]   xfer_idx;
  logic            hold_expire;

  rr_select #(
    .N_REQ (N_REQ),
    .IW    (GW)
  ) u_rr_select (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .valid (sel_valid),
    .index (sel_idx)
  );

  // Handshake: a byte moves when req_valid[i] && req_ready[i] at a rising edge;
  // req_ready never depends on the requester dropping valid, and is at most one-hot.
  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    xfer        = 1'b0;
    xfer_idx    = grant_q;
    hold_expire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && sel_valid) begin
          req_ready[sel_idx] = 1'b1;
          xfer               = 1'b1;
          xfer_idx           = sel_idx;
          state_d            = S_START;
        end
      end
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_done) state_d = last_q ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (!tx_busy) req_ready[grant_q] = 1'b1;
        // A byte arriving on the expiry cycle wins over the forced release.
        if (!tx_busy && req_valid[grant_q]) begin
          xfer    = 1'b1;
          state_d = S_START;
        end else if (hold_cnt_q == HCW'(HOLD_TIMEOUT - 1)) begin
          hold_expire = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      hold_cnt_q <= '0;
      hold_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_to_q <= hold_expire;
      if (xfer) begin
        tx_data_q <= req_data[int'(xfer_idx)*8 +: 8];
        last_q    <= req_last[xfer_idx];
        grant_q   <= xfer_idx;
      end
      if (state_q == S_WAIT_DONE && tx_done) begin
        if (last_q) rr_ptr_q <= GW'(wrap_inc(int'(grant_q), N_REQ));
        else        hold_cnt_q <= '0;
      end
      if (state_q == S_HOLD && !xfer && !hold_expire) hold_cnt_q <= hold_cnt_q + HCW'(1);
      if (hold_expire) rr_ptr_q <= GW'(wrap_inc(int'(grant_q), N_REQ));
    end
  end

  assign tx_start     = (state_q == S_START);
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_q;
  assign grant_active = (state_q != S_IDLE);
  assign hold_timeout = hold_to_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [8*N-1:0]   req_data;
  logic             tx_start, tx_busy, tx_done;
  logic [7:0]       tx_data;
  logic [1:0]       grant_id;
  logic             grant_active, hold_timeout;
  logic [1:0]       state_dbg;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .hold_timeout (hold_timeout),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [8:0]  stream [N][64];
  int          len [N];
  int          pos [N];
  logic [10:0] exp_q [$];
  int          rr_model;
  bit          uart_on;
  int          uart_cnt;
  bit          busy_force;
  int          cyc, done_cyc, start_cyc, to_cyc, to_delay, to_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input int r, input logic [7:0] d, input bit last);
    stream[r][len[r]] = {last, d};
    len[r]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (pos[i] < len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = stream[i][pos[i]][7:0];
        req_last[i]        = stream[i][pos[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  function automatic bit all_consumed();
    for (int i = 0; i < N; i++) if (pos[i] < len[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Whole packets are granted round-robin among requesters that still have data.
  task automatic build_expected();
    int cur [N];
    int w;
    bit fin;
    logic [8:0] b;
    for (int i = 0; i < N; i++) cur[i] = pos[i];
    for (int p = 0; p < 4 * 64; p++) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int r;
        r = (rr_model + k) % N;
        if (w < 0 && cur[r] < len[r]) w = r;
      end
      if (w < 0) break;
      fin = 1'b0;
      while (!fin && cur[w] < len[w]) begin
        b = stream[w][cur[w]];
        cur[w]++;
        exp_q.push_back({2'(w), b});
        fin = b[8];
      end
      rr_model = (w + 1) % N;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    busy_force = 1'b0;
    uart_on    = 1'b0;
    rr_model   = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin len[i] = 0; pos[i] = 0; end
    drive_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: sample handshake, advance, score tx_start, model the UART, redrive requesters.
  task automatic step();
    logic [N-1:0] acc;
    logic         done_pre;
    logic [10:0]  e;
    #2;
    acc      = req_valid & req_ready;
    done_pre = tx_done;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    chk("ready_while_busy", 32'(tx_busy & (|req_ready)), 0);
    @(posedge clk);
    #1;
    cyc++;
    if (done_pre) done_cyc = cyc;
    chk("start_latency", 32'(tx_start), 32'(acc != '0));
    if (hold_timeout === 1'b1) begin
      to_pulses++;
      to_cyc   = cyc;
      to_delay = cyc - done_cyc;
    end
    if (tx_start === 1'b1) begin
      start_cyc = cyc;
      chk("start_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("grant_id", 32'(grant_id), 32'(e[10:9]));
        chk("grant_active", 32'(grant_active), 1);
      end
      uart_on  = 1'b1;
      uart_cnt = $urandom_range(1, 4);
    end
    for (int i = 0; i < N; i++) if (acc[i]) pos[i]++;
    if (tx_done) begin
      tx_done = 1'b0;
      uart_on = 1'b0;
    end else if (uart_on && !tx_start) begin
      if (uart_cnt == 0) tx_done = 1'b1;
      else uart_cnt--;
    end
    tx_busy = uart_on | busy_force;
    drive_reqs();
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && all_consumed() && !uart_on) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    cyc = 0; done_cyc = 0; start_cyc = 0; to_cyc = 0; to_delay = 0; to_pulses = 0;
    req_valid = '0; req_last = '0; req_data = '0;
    do_reset();

    // reset values, with requests pending during reset
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_grant_active", 32'(grant_active), 0);
    chk("rst_hold_timeout", 32'(hold_timeout), 0);
    do_reset();

    // single byte from requester 0
    load_byte(0, 8'h55, 1'b1);
    build_expected();
    drive_reqs();
    run_drain(50);
    chk("idle_after_done", 32'(grant_active), 0);

    // four single bytes from reset, requester 0 queues a second one
    do_reset();
    for (int i = 0; i < N; i++) load_byte(i, 8'h10 + 8'(i), 1'b1);
    load_byte(0, 8'h50, 1'b1);
    build_expected();
    drive_reqs();
    run_drain(200);

    // three-byte packet on requester 1 keeps requester 2 waiting
    for (int i = 0; i < N; i++) begin len[i] = 0; pos[i] = 0; end
    load_byte(1, 8'hA1, 1'b0);
    load_byte(1, 8'hA2, 1'b0);
    load_byte(1, 8'hA3, 1'b1);
    load_byte(2, 8'h22, 1'b1);
    build_expected();
    drive_reqs();
    run_drain(200);

    // requester 1 stalls mid-packet: forced release, then requester 2
    do_reset();
    to_pulses = 0;
    load_byte(1, 8'h11, 1'b0);
    load_byte(2, 8'h22, 1'b1);
    exp_q.push_back({2'd1, 1'b0, 8'h11});
    exp_q.push_back({2'd2, 1'b1, 8'h22});
    drive_reqs();
    run_drain(200);
    chk("timeout_pulses", 32'(to_pulses), 1);
    chk("timeout_delay", 32'(to_delay), TO);
    chk("req2_after_timeout", 32'(start_cyc > to_cyc), 1);

    // transmitter busy blocks acceptance
    do_reset();
    load_byte(3, 8'h3C, 1'b1);
    build_expected();
    busy_force = 1'b1;
    tx_busy    = 1'b1;
    drive_reqs();
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("busy_blocks_ready", 32'(req_ready), 0);
    end
    busy_force = 1'b0;
    tx_busy    = 1'b0;
    #1;
    chk("ready_after_busy", 32'(req_ready), 32'h8);
    run_drain(50);

    // reset while waiting for tx_done, then a stray tx_done
    for (int i = 0; i < N; i++) begin len[i] = 0; pos[i] = 0; end
    load_byte(2, 8'h77, 1'b1);
    build_expected();
    drive_reqs();
    for (int i = 0; i < 20; i++) if (exp_q.size() != 0) step();
    step();
    rst = 1'b1;
    #1;
    chk("abort_tx_start", 32'(tx_start), 0);
    chk("abort_tx_data", 32'(tx_data), 0);
    chk("abort_grant_id", 32'(grant_id), 0);
    chk("abort_grant_active", 32'(grant_active), 0);
    chk("abort_hold_timeout", 32'(hold_timeout), 0);
    chk("abort_req_ready", 32'(req_ready), 0);
    uart_on = 1'b0;
    tx_busy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tx_done = 1'b1;
    rr_model = 0;
    for (int i = 0; i < 6; i++) step();
    chk("stray_done_ignored", 32'(grant_active), 0);
    chk("stray_done_tx_data", 32'(tx_data), 0);

    // randomized packets on all requesters
    do_reset();
    to_pulses = 0;
    for (int i = 0; i < N; i++) begin
      int npk;
      npk = $urandom_range(0, 4);
      for (int p = 0; p < npk; p++) begin
        int plen;
        plen = $urandom_range(1, 3);
        for (int b = 0; b < plen; b++)
          load_byte(i, 8'($urandom_range(0, 255)), b == plen - 1);
      end
    end
    build_expected();
    drive_reqs();
    run_drain(3000);
    chk("random_no_timeout", 32'(to_pulses), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 1024, clk cycles a packet owner may idle in HOLD before forced release.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*N_REQ  per-requester byte, requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  N_REQ  byte is last of packet; sampled with req_data.
REQ-008 SHALL have port req_ready  output  N_REQ  byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to transmit, stable from tx_start until tx_done.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy.
REQ-012 SHALL have port tx_done  input  1  one-cycle pulse, byte finished on line.
REQ-013 SHALL have port grant_id  output  clog2(N_REQ)  current/last owner index.
REQ-014 SHALL have port grant_active  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port hold_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT_DONE, HOLD.
REQ-017 IDLE: when tx_busy=0 and any req_valid, SHALL select winner by round-robin starting at rr_ptr, wrapping N_REQ-1 -> 0.
REQ-018 req_ready SHALL be combinational, one-hot or zero: winner bit in IDLE with tx_busy=0; grant_id bit in HOLD with tx_busy=0; zero in START and WAIT_DONE.
REQ-019 On transfer SHALL register req_data into tx_data, req_last into last_reg, set grant_id, go START.
REQ-020 START: SHALL assert tx_start for exactly one cycle, go WAIT_DONE.
REQ-021 WAIT_DONE: on tx_done with last_reg=1 SHALL set rr_ptr = grant_id+1 (mod N_REQ), go IDLE; with last_reg=0 SHALL go HOLD and clear hold counter.
REQ-022 HOLD: SHALL grant only grant_id; other requesters wait regardless of priority.
REQ-023 HOLD: hold counter SHALL increment each cycle without transfer; at HOLD_TIMEOUT-1 SHALL pulse hold_timeout, set rr_ptr = grant_id+1, go IDLE.
REQ-024 Transfer in HOLD on the timeout cycle SHALL take precedence; no hold_timeout pulse.
REQ-025 tx_done outside WAIT_DONE SHALL be ignored.
REQ-026 Latency: transfer cycle N -> tx_start at N+1; tx_done at M -> next transfer possible at M+1 (IDLE or HOLD).
REQ-027 Single active requester SHALL be re-granted after its packet ends (round-robin skips idle requesters).
REQ-028 Requesters SHALL hold req_valid/req_data/req_last until accepted; block does not check this.

Reset
REQ-029 On rst: state IDLE, rr_ptr 0, grant_id 0, tx_data 0x00, last_reg 0, hold counter 0, tx_start 0, hold_timeout 0, grant_active 0, req_ready 0.
REQ-030 rst mid-transfer SHALL abort immediately; no tx_start pulse follows release of rst until a new transfer.

Structure
REQ-031 State encoding and hold-counter width SHALL be localparams in the module; no shared package needed.
REQ-032 Round-robin winner selection SHALL be sub-module rr_select (inputs req, ptr; outputs valid, index).

Verification
REQ-033 One requester: req0 sends 0x55 last=1 -> tx_start one cycle after transfer, tx_data=0x55, returns IDLE after tx_done.
REQ-034 All four valid single bytes from reset -> grant order 0,1,2,3, then 0 if still valid.
REQ-035 req1 packet 0xA1,0xA2,0xA3 (last on third) while req2 valid -> req2 served only after 0xA3 tx_done.
REQ-036 req1 last=0 then drops valid, HOLD_TIMEOUT=16 -> hold_timeout pulse 16 cycles after entering HOLD, req2 granted next.
REQ-037 tx_busy=1 with req_valid high -> req_ready stays 0 until tx_busy=0.
REQ-038 rst asserted in WAIT_DONE -> all outputs at reset values same cycle; spurious tx_done after reset ignored.
